seq_signed_multiplier: RTL and testbench

- Parametrised, multi-cycle signed multiplier. Successor to the team's 4-bit combinational sign-magnitude multiplier.
- Multiplies two W-bit operands by iterative radix-2 shift-add on operand magnitudes. A per-operation mode selects sign-magnitude or two's-complement encoding.
- start/busy/done handshake. Sits beside the ALU datapath, where area matters more than latency.

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_operand_cond.sv | 30 +++
 rtl/seq_signed_multiplier.sv | 161 ++++++++++++++++
 tb/tb_seq_signed_multiplier.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential signed multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } state_t;

  localparam logic MODE_SM = 1'b0;
  localparam logic MODE_TC = 1'b1;

  // Width of the iteration counter; counts 0..W-1.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mult_operand_cond.sv
// Splits one operand into sign and unsigned magnitude for either encoding.
module mult_operand_cond
  import mult_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic         mode,
  output logic         sign,
  output logic [W-1:0] mag
);

  // TC magnitude of -2^(W-1) is 2^(W-1), which still fits in W unsigned bits.
  always_comb begin
    sign = x[W-1];
    mag  = {W{1'b0}};
    case (mode)
      MODE_SM: mag = {1'b0, x[W-2:0]};
      MODE_TC: begin
        if (x[W-1]) begin
          mag = ~x + {{(W-1){1'b0}}, 1'b1};
        end else begin
          mag = x;
        end
      end
      default: mag = {W{1'b0}};
    endcase
  end

endmodule

// File: rtl/seq_signed_multiplier.sv
// Multi-cycle signed multiplier: radix-2 shift-add on magnitudes, sign applied last.
module seq_signed_multiplier
  import mult_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int            CW       = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     mplr_q, mplr_d;
  logic [W-1:0]     mag_a_q, mag_a_d;
  logic             sign_q, sign_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2*W-1:0]   p_q, p_d;

  logic             sign_a_s, sign_b_s;
  logic [W-1:0]     mag_a_s, mag_b_s;
  logic [2*W-1:0]   addend_s;
  logic [2*W-1:0]   result_s;

  mult_operand_cond #(.W(W)) u_cond_a (
    .x    (a),
    .mode (mode),
    .sign (sign_a_s),
    .mag  (mag_a_s)
  );

  mult_operand_cond #(.W(W)) u_cond_b (
    .x    (b),
    .mode (mode),
    .sign (sign_b_s),
    .mag  (mag_b_s)
  );

  assign addend_s = {{W{1'b0}}, mag_a_q} << cnt_q;

  // SM never yields negative zero; TC negates the whole 2W-bit accumulator.
  always_comb begin
    result_s = acc_q;
    case (mode_q)
      MODE_SM: begin
        if (acc_q == {(2*W){1'b0}}) begin
          result_s = {(2*W){1'b0}};
        end else begin
          result_s = {sign_q, acc_q[2*W-2:0]};
        end
      end
      MODE_TC: begin
        if (sign_q) begin
          result_s = ~acc_q + {{(2*W-1){1'b0}}, 1'b1};
        end else begin
          result_s = acc_q;
        end
      end
      default: result_s = {(2*W){1'b0}};
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    mag_a_d = mag_a_q;
    sign_d  = sign_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          mag_a_d = mag_a_s;
          mplr_d  = mag_b_s;
          sign_d  = sign_a_s ^ sign_b_s;
          acc_d   = {(2*W){1'b0}};
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        if (mplr_q[0]) begin
          acc_d = acc_q + addend_s;
        end else begin
          acc_d = acc_q;
        end
        mplr_d = mplr_q >> 1;
        cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          state_d = SIGN;
        end else begin
          state_d = RUN;
        end
      end
      SIGN: begin
        p_d     = result_s;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // All state and outputs are registered; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      acc_q   <= {(2*W){1'b0}};
      mplr_q  <= {W{1'b0}};
      mag_a_q <= {W{1'b0}};
      sign_q  <= 1'b0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= {(2*W){1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      mag_a_q <= mag_a_d;
      sign_q  <= sign_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      p_q     <= p_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Scoreboard bench for seq_signed_multiplier at W=4 (directed) and W=8 (sampled sweep).
module tb_seq_signed_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start4 = 1'b0, mode4 = 1'b0;
  logic [3:0]  a4 = 4'h0, b4 = 4'h0;
  logic        busy4, done4;
  logic [7:0]  p4;

  logic        start8 = 1'b0, mode8 = 1'b0;
  logic [7:0]  a8 = 8'h0, b8 = 8'h0;
  logic        busy8, done8;
  logic [15:0] p8;

  seq_signed_multiplier #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .p(p4)
  );

  seq_signed_multiplier #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  typedef struct {
    logic [15:0] p;
    int          edge_n;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent reference: signed integer product (TC) or sign|magnitude (SM).
  function automatic logic [15:0] ref_p(int w, bit md, logic [7:0] a, logic [7:0] b);
    longint sa, sb, pr, msk;
    msk = (longint'(1) << (2 * w)) - 1;
    if (md) begin
      sa = longint'(a);
      sb = longint'(b);
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
      pr = sa * sb;
      return 16'(pr & msk);
    end else begin
      sa = longint'(a) & ((longint'(1) << (w - 1)) - 1);
      sb = longint'(b) & ((longint'(1) << (w - 1)) - 1);
      pr = sa * sb;
      if (pr == 0) return 16'h0;
      return 16'(pr | (longint'(a[w-1] ^ b[w-1]) << (2 * w - 1)));
    end
  endfunction

  // Scoreboard pop on every done pulse; also checks latency via expected edge.
  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) begin
        chk("spurious_done4", 32'(done4), 32'd0);
      end else begin
        e4 = q4.pop_front();
        chk("p4", 32'(p4), 32'(e4.p));
        chk("lat4", 32'(cyc), 32'(e4.edge_n));
      end
    end
    if (done8) begin
      if (q8.size() == 0) begin
        chk("spurious_done8", 32'(done8), 32'd0);
      end else begin
        e8 = q8.pop_front();
        chk("p8", 32'(p8), 32'(e8.p));
        chk("lat8", 32'(cyc), 32'(e8.edge_n));
      end
    end
  end

  task automatic issue4(input bit md, input logic [3:0] a, input logic [3:0] b);
    mode4 = md; a4 = a; b4 = b; start4 = 1'b1;
    q4.push_back('{p: ref_p(4, md, {4'h0, a}, {4'h0, b}), edge_n: cyc + 1 + 5});
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic issue8(input bit md, input logic [7:0] a, input logic [7:0] b);
    mode8 = md; a8 = a; b8 = b; start8 = 1'b1;
    q8.push_back('{p: ref_p(8, md, a, b), edge_n: cyc + 1 + 9});
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic wait4();
    for (int i = 0; i < 40 && q4.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    chk("timeout4", 32'(q4.size()), 32'd0);
  endtask

  task automatic wait8();
    for (int i = 0; i < 40 && q8.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    chk("timeout8", 32'(q8.size()), 32'd0);
  endtask

  initial begin
    int busy_cnt;
    int n;

    // Reset state
    #22;
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    chk("rst_p4", 32'(p4), 32'd0);
    chk("rst_p8", 32'(p8), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // SM +3 * -2 = 0x86, busy exactly 5 cycles
    issue4(1'b0, 4'b0011, 4'b1010);
    busy_cnt = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (busy4) busy_cnt++;
    end
    chk("busy_cycles", 32'(busy_cnt - 1), 32'd5);
    wait4();

    // TC corner cases
    issue4(1'b1, 4'b1000, 4'b1000); wait4();
    issue4(1'b1, 4'b0111, 4'b1111); wait4();

    // SM negative zero, with p hold check while busy (previous p = 0xF9)
    issue4(1'b0, 4'b1000, 4'b0101);
    @(negedge clk); @(negedge clk); #1;
    chk("p_hold", 32'(p4), 32'h0F9);
    wait4();

    // Assorted operands, issued back to back from the done cycle
    issue4(1'b0, 4'b1111, 4'b1111); wait4();
    issue4(1'b1, 4'b0101, 4'b1101); wait4();
    issue4(1'b1, 4'b0000, 4'b0111); wait4();

    // Start held for 12 edges; operands changed mid-RUN of each op
    @(posedge clk); #1;
    n = cyc;
    mode4 = 1'b1; a4 = 4'b0101; b4 = 4'b0011; start4 = 1'b1;
    q4.push_back('{p: ref_p(4, 1'b1, 8'h05, 8'h03), edge_n: n + 6});
    repeat (2) @(posedge clk); #1;
    mode4 = 1'b0; a4 = 4'b1011; b4 = 4'b0110;
    q4.push_back('{p: ref_p(4, 1'b0, 8'h0B, 8'h06), edge_n: n + 12});
    repeat (6) @(posedge clk); #1;
    mode4 = 1'b1; a4 = 4'b1001; b4 = 4'b0111;
    repeat (4) @(posedge clk); #1;
    start4 = 1'b0;
    wait4();
    repeat (8) @(negedge clk);
    chk("handshake_q_empty", 32'(q4.size()), 32'd0);

    // Asynchronous reset while count == 2
    @(posedge clk); #1;
    issue4(1'b1, 4'b0011, 4'b0011);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy4", 32'(busy4), 32'd0);
    chk("abort_done4", 32'(done4), 32'd0);
    chk("abort_p4", 32'(p4), 32'd0);
    void'(q4.pop_back());
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("idle_after_rst", 32'(busy4), 32'd0);

    // W=8 corners then a sampled sweep over both modes
    @(posedge clk); #1;
    issue8(1'b1, 8'h80, 8'h80); wait8();
    issue8(1'b1, 8'h7F, 8'h81); wait8();
    issue8(1'b0, 8'hFF, 8'hFF); wait8();
    issue8(1'b0, 8'h80, 8'h05); wait8();
    issue8(1'b1, 8'h00, 8'h80); wait8();
    issue8(1'b0, 8'h7F, 8'h7F); wait8();
    for (int i = 0; i < 1500; i++) begin
      issue8(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait8();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
